// File: rtl/tinker_pkg.sv
// Shared definitions for the tinker fetch unit and decoder: instruction
// layout, fetch FSM states and PC helpers.
package tinker_pkg;

  localparam int XLEN        = 64;
  localparam int INSTR_BYTES = 4;

  // Instruction field layout consumed by the decoder
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RD_MSB  = 26;
  localparam int RD_LSB  = 22;
  localparam int RS_MSB  = 21;
  localparam int RS_LSB  = 17;
  localparam int RT_MSB  = 16;
  localparam int RT_LSB  = 12;
  localparam int L_MSB   = 11;
  localparam int L_LSB   = 0;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_ERROR = 2'd2
  } fetch_state_t;

  // Instructions are word aligned; redirect targets must be too
  function automatic logic pc_aligned(input logic [1:0] pc_lsbs);
    return pc_lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/tinker_fetch.sv
// Instruction fetch: reads four little-endian bytes over a byte-wide
// req/ack port, assembles them and offers the word on valid/ready.
// Redirects never abort a byte request in flight; instead the pending
// byte is dropped when it arrives.
module tinker_fetch
  import tinker_pkg::*;
#(
  parameter int               XLEN     = tinker_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = 64'h0000_0000_0000_2000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            mem_req,
  output logic [XLEN-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_err
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [1:0]      beat_q, beat_d;
  logic            discard_q, discard_d;   // next acked byte is dropped
  logic            err_pend_q, err_pend_d; // drop goes to ERROR, not rpc
  logic [XLEN-1:0] rpc_q, rpc_d;           // latched redirect target
  logic [31:0]     instr_q, instr_d;
  logic            instr_vld_q, instr_vld_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;
  logic            ferr_q, ferr_d;
  logic            mem_req_q, mem_req_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;

  logic xfer;
  logic mis;

  assign xfer = mem_req_q & mem_ack;
  assign mis  = ~pc_aligned(redirect_pc[1:0]);

  // Next-state logic for the fetch FSM and datapath
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    beat_d      = beat_q;
    discard_d   = discard_q;
    err_pend_d  = err_pend_q;
    rpc_d       = rpc_q;
    instr_d     = instr_q;
    instr_vld_d = instr_vld_q;
    instr_pc_d  = instr_pc_q;
    ferr_d      = ferr_q;

    unique case (state_q)
      ST_FETCH: begin
        if (redirect_valid) begin
          if (mis) begin
            ferr_d      = 1'b1;
            instr_vld_d = 1'b0;
            if (mem_req_q && !mem_ack) begin
              // Byte in flight: finish the handshake, then enter ERROR
              discard_d  = 1'b1;
              err_pend_d = 1'b1;
            end else begin
              state_d    = ST_ERROR;
              beat_d     = 2'd0;
              discard_d  = 1'b0;
              err_pend_d = 1'b0;
            end
          end else if (mem_req_q && !mem_ack) begin
            // Hold the address until ack, then jump to the latched target
            discard_d  = 1'b1;
            rpc_d      = redirect_pc;
            err_pend_d = 1'b0;
            if (err_pend_q) ferr_d = 1'b0;
          end else begin
            // Acked byte this cycle (or no request yet) is simply dropped
            pc_d       = redirect_pc;
            beat_d     = 2'd0;
            discard_d  = 1'b0;
            err_pend_d = 1'b0;
          end
        end else if (xfer) begin
          if (discard_q) begin
            beat_d     = 2'd0;
            discard_d  = 1'b0;
            err_pend_d = 1'b0;
            if (err_pend_q) state_d = ST_ERROR;
            else            pc_d    = rpc_q;
          end else begin
            instr_d[{beat_q, 3'b000} +: 8] = mem_rdata;
            beat_d = beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              instr_pc_d  = pc_q;
              instr_vld_d = 1'b1;
              state_d     = ST_HOLD;
              beat_d      = 2'd0;
            end
          end
        end
      end

      ST_HOLD: begin
        if (redirect_valid) begin
          instr_vld_d = 1'b0;
          if (mis) begin
            ferr_d  = 1'b1;
            state_d = ST_ERROR;
          end else begin
            pc_d    = redirect_pc;
            state_d = ST_FETCH;
          end
        end else if (instr_vld_q && instr_ready) begin
          instr_vld_d = 1'b0;
          pc_d        = pc_q + XLEN'(INSTR_BYTES);
          state_d     = ST_FETCH;
        end
      end

      ST_ERROR: begin
        instr_vld_d = 1'b0;
        if (redirect_valid && !mis) begin
          pc_d    = redirect_pc;
          beat_d  = 2'd0;
          ferr_d  = 1'b0;
          state_d = ST_FETCH;
        end
      end

      default: begin
        state_d = ST_FETCH;
        beat_d  = 2'd0;
      end
    endcase
  end

  // Memory port is registered off the next state; address only moves when
  // pc or beat move, which happens only on ack
  always_comb begin
    mem_req_d  = (state_d == ST_FETCH);
    mem_addr_d = mem_addr_q;
    if (mem_req_d) mem_addr_d = pc_d + {{(XLEN-2){1'b0}}, beat_d};
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_FETCH;
      pc_q        <= RESET_PC;
      beat_q      <= 2'd0;
      discard_q   <= 1'b0;
      err_pend_q  <= 1'b0;
      rpc_q       <= '0;
      instr_q     <= '0;
      instr_vld_q <= 1'b0;
      instr_pc_q  <= '0;
      ferr_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      beat_q      <= beat_d;
      discard_q   <= discard_d;
      err_pend_q  <= err_pend_d;
      rpc_q       <= rpc_d;
      instr_q     <= instr_d;
      instr_vld_q <= instr_vld_d;
      instr_pc_q  <= instr_pc_d;
      ferr_q      <= ferr_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign instr_valid = instr_vld_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_err   = ferr_q;

endmodule

// File: tb/tb_tinker_fetch.sv
// Directed bench for tinker_fetch with a byte memory model.
module tb_tinker_fetch;

  logic        clk;
  logic        rst_n;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_err;

  int nchk = 0;
  int nerr = 0;

  logic [7:0] mem [logic [63:0]];

  tinker_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rd(input logic [63:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  // Advance one cycle; sample/drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    mem_rdata = rd(mem_addr);
  endtask

  task automatic put_word(input logic [63:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem[a + 64'(i)] = w[8*i +: 8];
  endtask

  // Fetch with mem_ack high; bounded wait for instr_valid
  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, instr_valid, 1'b1);
  endtask

  initial begin
    logic [31:0] s_instr;
    logic [63:0] s_pc;

    rst_n = 1'b0; mem_ack = 1'b1; mem_rdata = 8'h00; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    put_word(64'h2000, 32'h1234_5678);
    put_word(64'h2004, 32'hDEAD_BEEF);
    put_word(64'h2008, 32'hCAFE_F00D);
    put_word(64'h3000, 32'h0403_0201);
    put_word(64'h4000, 32'hDDCC_BBAA);

    tick(); tick();
    chk("rst_req", mem_req, 1'b0);
    chk("rst_addr", mem_addr, 64'h0);
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 64'h0);
    chk("rst_err", fetch_err, 1'b0);
    rst_n = 1'b1;
    #1 chk("rel_req_low", mem_req, 1'b0);

    // Basic fetch
    tick();
    chk("b_req", mem_req, 1'b1);
    chk("b_a0", mem_addr, 64'h2000);
    tick(); chk("b_a1", mem_addr, 64'h2001);
    tick(); chk("b_a2", mem_addr, 64'h2002);
    tick(); chk("b_a3", mem_addr, 64'h2003);
    chk("b_novalid", instr_valid, 1'b0);
    tick();
    chk("b_valid", instr_valid, 1'b1);
    chk("b_instr", instr, 32'h1234_5678);
    chk("b_ipc", instr_pc, 64'h2000);
    chk("b_req_hold", mem_req, 1'b0);

    // Backpressure
    s_instr = instr; s_pc = instr_pc;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_instr", instr, 32'h1234_5678);
      chk("bp_ipc", instr_pc, 64'h2000);
      chk("bp_req", mem_req, 1'b0);
      chk("bp_valid", instr_valid, 1'b1);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0; mem_ack = 1'b0;
    chk("bp_consumed", instr_valid, 1'b0);
    chk("bp_next_req", mem_req, 1'b1);
    chk("bp_next_addr", mem_addr, 64'h2004);

    // Wait states: ack only every third cycle
    for (int b = 0; b < 4; b++) begin
      mem_ack = 1'b0;
      chk("ws_addr0", mem_addr, 64'h2004 + 64'(b));
      tick(); chk("ws_addr1", mem_addr, 64'h2004 + 64'(b));
      tick(); chk("ws_addr2", mem_addr, 64'h2004 + 64'(b));
      mem_ack = 1'b1;
      tick();
    end
    chk("ws_valid", instr_valid, 1'b1);
    chk("ws_instr", instr, 32'hDEAD_BEEF);
    chk("ws_ipc", instr_pc, 64'h2004);

    // Redirect mid-beat with no ack
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("rd_a0", mem_addr, 64'h2008);
    tick(); tick();
    chk("rd_a2", mem_addr, 64'h200A);
    mem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h3000;
    tick();
    redirect_valid = 1'b0;
    chk("rd_hold_req", mem_req, 1'b1);
    chk("rd_hold_a", mem_addr, 64'h200A);
    tick();
    chk("rd_hold_a2", mem_addr, 64'h200A);
    mem_ack = 1'b1;
    tick();
    chk("rd_new_a", mem_addr, 64'h3000);
    wait_valid("rd");
    chk("rd_instr", instr, 32'h0403_0201);
    chk("rd_ipc", instr_pc, 64'h3000);

    // Handshake and redirect together in HOLD
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h4000;
    tick();
    instr_ready = 1'b0; redirect_valid = 1'b0;
    chk("hr_valid", instr_valid, 1'b0);
    chk("hr_addr", mem_addr, 64'h4000);
    wait_valid("hr");
    chk("hr_instr", instr, 32'hDDCC_BBAA);
    chk("hr_ipc", instr_pc, 64'h4000);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("hr_next", mem_addr, 64'h4004);

    // Misaligned redirect with the current byte acked
    redirect_valid = 1'b1; redirect_pc = 64'h2002;
    tick();
    redirect_valid = 1'b0;
    chk("mis_err", fetch_err, 1'b1);
    chk("mis_req", mem_req, 1'b0);
    tick(); tick();
    chk("mis_err_stk", fetch_err, 1'b1);
    chk("mis_req_stk", mem_req, 1'b0);
    chk("mis_valid", instr_valid, 1'b0);
    redirect_valid = 1'b1; redirect_pc = 64'h2008;
    tick();
    redirect_valid = 1'b0;
    chk("clr_err", fetch_err, 1'b0);
    chk("clr_req", mem_req, 1'b1);
    chk("clr_addr", mem_addr, 64'h2008);
    tick();
    chk("clr_a1", mem_addr, 64'h2009);

    // Async reset mid-beat
    #2 rst_n = 1'b0;
    #1;
    chk("ar_req", mem_req, 1'b0);
    chk("ar_addr", mem_addr, 64'h0);
    chk("ar_err", fetch_err, 1'b0);
    chk("ar_valid", instr_valid, 1'b0);
    chk("ar_instr", instr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("ar_restart", mem_addr, 64'h2000);
    chk("ar_req1", mem_req, 1'b1);

    // Misaligned redirect while a byte is outstanding: ERROR after the ack
    mem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h2002;
    tick();
    redirect_valid = 1'b0;
    chk("dm_req_held", mem_req, 1'b1);
    chk("dm_addr_held", mem_addr, 64'h2000);
    chk("dm_err", fetch_err, 1'b1);
    mem_ack = 1'b1;
    tick();
    chk("dm_req_off", mem_req, 1'b0);
    chk("dm_err2", fetch_err, 1'b1);
    redirect_valid = 1'b1; redirect_pc = 64'h2000;
    tick();
    redirect_valid = 1'b0;
    chk("dm_resume", mem_addr, 64'h2000);
    wait_valid("dm");
    chk("dm_instr", instr, 32'h1234_5678);
    chk("dm_ipc", instr_pc, 64'h2000);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
